// File: rtl/vic20_bus_sched.sv
// vic20_bus_sched
// Divides the 25 MHz clock into a repeating 25-cycle (1 us) frame and shares
// the single RAM port between the CPU and the video fetcher.
//
// Ports:
//   clk25, reset                   clock and synchronous active-high reset
//   turbo[1:0]                     CPU rate select (00 1 MHz, 01 2 MHz, 1x 4 MHz)
//   cpu_addr/cpu_dout/cpu_rnw      registered CPU bus
//   cpu_clken, cpu_din             CPU advance strobe and read data
//   via1_clken, via4_clken         VIA phase-2 and 4x enables
//   via1_cs, via2_cs, via*_dout    VIA selects and read data
//   vid_req/vid_addr/vid_ack       video fetch request handshake
//   vid_valid, vid_data            fetched byte, one cycle after ack
//   ram_addr/ram_we/ram_din/ram_dout  dpram port (registered read)
module vic20_bus_sched #(
  parameter int FRAME_LEN = 25,
  parameter int VID_FIRST = 16,
  parameter int VID_LAST  = 23
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic [1:0]  turbo,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rnw,
  output logic        cpu_clken,
  output logic [7:0]  cpu_din,
  output logic        via1_clken,
  output logic        via4_clken,
  output logic        via1_cs,
  output logic        via2_cs,
  input  logic [7:0]  via1_dout,
  input  logic [7:0]  via2_dout,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_valid,
  output logic [7:0]  vid_data,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  localparam logic [4:0] LAST_PHASE = 5'(FRAME_LEN - 1);

  logic [4:0] phase_q, phase_d;
  logic [1:0] tmode_q, tmode_d;
  logic       vid_valid_q, vid_valid_d;

  logic        rate_2m, rate_4m;
  logic        in_video, slot_hit, pre_slot, via4_hit, ack;
  logic [15:0] vid_ram_addr;

  always_comb begin
    rate_4m  = tmode_q[1];
    rate_2m  = (tmode_q == 2'b01);
    in_video = (phase_q >= 5'(VID_FIRST)) && (phase_q <= 5'(VID_LAST));

    slot_hit = (phase_q == 5'd0)
            || ((rate_2m || rate_4m) && (phase_q == 5'd8))
            || (rate_4m && ((phase_q == 5'd4) || (phase_q == 5'd12)));

    // The write strobe lands in the last cycle before each CPU slot, so the
    // registered address/data have been stable for the whole CPU cycle.
    pre_slot = (phase_q == LAST_PHASE)
            || ((rate_2m || rate_4m) && (phase_q == 5'd7))
            || (rate_4m && ((phase_q == 5'd3) || (phase_q == 5'd11)));

    via4_hit = (phase_q < 5'd16)
            && (rate_4m
                || (rate_2m && !phase_q[0])
                || (!rate_2m && !rate_4m && (phase_q[1:0] == 2'b00)));

    ack = !reset && in_video && vid_req;

    // bit 13 clear selects the $8000 half of the 64K space
    vid_ram_addr = vid_addr[13] ? {3'b000, vid_addr[12:0]}
                                : {3'b100, vid_addr[12:0]};

    phase_d     = (phase_q == LAST_PHASE) ? 5'd0 : phase_q + 5'd1;
    // rate changes only at the frame boundary so a frame never gains or
    // loses a slot
    tmode_d     = (phase_q == LAST_PHASE) ? turbo : tmode_q;
    vid_valid_d = ack;
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      phase_q     <= 5'd0;
      tmode_q     <= 2'b00;
      vid_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      tmode_q     <= tmode_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  assign cpu_clken  = !reset && slot_hit;
  assign via1_clken = cpu_clken;
  assign via4_clken = !reset && via4_hit;

  assign vid_ack  = ack;
  assign ram_addr = ack ? vid_ram_addr : cpu_addr;
  assign ram_we   = !reset && !in_video && pre_slot && !cpu_rnw;
  assign ram_din  = cpu_dout;

  // Gated by reset so a fetch in flight is dropped in the reset cycle itself.
  assign vid_valid = vid_valid_q && !reset;
  assign vid_data  = vid_valid ? ram_dout : 8'h00;

  assign via1_cs = (cpu_addr[15:4] == 12'h911);
  assign via2_cs = (cpu_addr[15:4] == 12'h912);
  assign cpu_din = via1_cs ? via1_dout : (via2_cs ? via2_dout : ram_dout);

endmodule

// File: tb/tb_vic20_bus_sched.sv
module tb_vic20_bus_sched;

  logic        clk25 = 1'b0;
  logic        reset;
  logic [1:0]  turbo;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rnw;
  logic        cpu_clken;
  logic [7:0]  cpu_din;
  logic        via1_clken, via4_clken, via1_cs, via2_cs;
  logic [7:0]  via1_dout, via2_dout;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        vid_ack, vid_valid;
  logic [7:0]  vid_data;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  vic20_bus_sched dut (
    .clk25(clk25), .reset(reset), .turbo(turbo),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
    .cpu_clken(cpu_clken), .cpu_din(cpu_din),
    .via1_clken(via1_clken), .via4_clken(via4_clken),
    .via1_cs(via1_cs), .via2_cs(via2_cs),
    .via1_dout(via1_dout), .via2_dout(via2_dout),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #20 clk25 = ~clk25;

  int checks = 0;
  int errors = 0;

  // behavioural model: frame position, latched rate, RAM contents
  logic [7:0] mem [0:65535];
  int         m_phase;
  int         m_tm;       // 0 = 1 MHz, 1 = 2 MHz, 2 = 4 MHz
  bit         m_vvalid;
  logic [7:0] m_vdata;
  bit         last_ack;

  function automatic bit in_slot(int ph, int tm);
    case (tm)
      0:       return ph == 0;
      1:       return ph == 0 || ph == 8;
      default: return ph == 0 || ph == 4 || ph == 8 || ph == 12;
    endcase
  endfunction

  function automatic bit before_slot(int ph, int tm);
    return ph == 24 || (ph < 24 && in_slot(ph + 1, tm));
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t phase=%0d)", nm, act, exp, $time, m_phase);
    end
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic tick();
    bit          r, vid, e_clk, e_v4, e_ack, e_we, e_valid, cs1, cs2;
    int          ph, tm;
    logic [15:0] vaddr, e_addr;
    logic [7:0]  e_din, e_vdata;
    #1;
    r     = reset;
    ph    = m_phase;
    tm    = m_tm;
    vid   = (ph >= 16) && (ph <= 23);
    e_clk = !r && in_slot(ph, tm);
    e_v4  = !r && ph < 16 && (tm == 2 || (tm == 1 && ph % 2 == 0) || (tm == 0 && ph % 4 == 0));
    e_ack = !r && vid && vid_req;
    vaddr = vid_addr[13] ? {3'b000, vid_addr[12:0]} : {3'b100, vid_addr[12:0]};
    e_addr = e_ack ? vaddr : cpu_addr;
    e_we  = !r && !vid && before_slot(ph, tm) && !cpu_rnw;
    cs1   = (cpu_addr >= 16'h9110) && (cpu_addr <= 16'h911F);
    cs2   = (cpu_addr >= 16'h9120) && (cpu_addr <= 16'h912F);
    e_din = cs1 ? via1_dout : (cs2 ? via2_dout : ram_dout);
    e_valid = !r && m_vvalid;
    e_vdata = e_valid ? m_vdata : 8'h00;

    chk("cpu_clken",  16'(cpu_clken),  16'(e_clk));
    chk("via1_clken", 16'(via1_clken), 16'(e_clk));
    chk("via4_clken", 16'(via4_clken), 16'(e_v4));
    chk("via1_cs",    16'(via1_cs),    16'(cs1));
    chk("via2_cs",    16'(via2_cs),    16'(cs2));
    chk("cpu_din",    16'(cpu_din),    16'(e_din));
    chk("vid_ack",    16'(vid_ack),    16'(e_ack));
    chk("vid_valid",  16'(vid_valid),  16'(e_valid));
    chk("vid_data",   16'(vid_data),   16'(e_vdata));
    chk("ram_addr",   ram_addr,        e_addr);
    chk("ram_we",     16'(ram_we),     16'(e_we));
    chk("ram_din",    16'(ram_din),    16'(cpu_dout));

    @(posedge clk25);
    if (r) begin
      m_phase  = 0;
      m_tm     = 0;
      m_vvalid = 0;
    end else begin
      if (m_phase == 24) m_tm = turbo[1] ? 2 : int'(turbo[0]);
      m_phase  = (m_phase + 1) % 25;
      m_vvalid = e_ack;
    end
    m_vdata  = mem[e_addr];
    ram_dout = mem[e_addr];
    if (e_we) mem[e_addr] = cpu_dout;
    last_ack = e_ack;
    @(negedge clk25);
  endtask

  task automatic run_to(input int p);
    int n = 0;
    while (m_phase != p && n < 80) begin
      tick();
      n++;
    end
    if (m_phase != p) begin
      checks++;
      errors++;
      $display("FAIL run_to: phase %0d expected %0d (timeout)", m_phase, p);
    end
  endtask

  initial begin
    int clk_pos[$];
    int v4_cnt, cnt, first_ack, vcnt;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset = 1'b1; turbo = 2'b00; cpu_addr = 16'h4321; cpu_dout = 8'hA5;
    cpu_rnw = 1'b0; via1_dout = 8'h11; via2_dout = 8'h22;
    vid_req = 1'b0; vid_addr = 14'h0; ram_dout = 8'h00;
    m_phase = 0; m_tm = 0; m_vvalid = 0; m_vdata = 8'h00; last_ack = 0;

    @(negedge clk25);
    #1;
    chk("rst_cpu_clken", 16'(cpu_clken), 16'h0);
    chk("rst_ram_we",    16'(ram_we),    16'h0);
    chk("rst_ram_addr",  ram_addr,       16'h4321);
    chk("rst_vid_valid", 16'(vid_valid), 16'h0);
    tick(); tick();
    reset = 1'b0; cpu_rnw = 1'b1;

    // 1 MHz over three frames
    v4_cnt = 0;
    for (int i = 0; i < 75; i++) begin
      #1;
      if (cpu_clken) clk_pos.push_back(i);
      if (via4_clken) v4_cnt++;
      tick();
    end
    chk("1m_clken_count", 16'(clk_pos.size()), 16'd3);
    if (clk_pos.size() == 3) begin
      chk("1m_pos0", 16'(clk_pos[0]), 16'd0);
      chk("1m_pos1", 16'(clk_pos[1]), 16'd25);
      chk("1m_pos2", 16'(clk_pos[2]), 16'd50);
    end
    chk("1m_via4_count", 16'(v4_cnt), 16'd12);

    // 00 -> 01 mid-frame: no new slots until next frame
    run_to(5);
    turbo = 2'b01;
    cnt = 0;
    for (int i = 5; i < 25; i++) begin
      #1; if (cpu_clken) cnt++;
      tick();
    end
    chk("turbo_same_frame", 16'(cnt), 16'd0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      #1;
      if (cpu_clken) cnt++;
      if (i == 8) chk("2m_slot8", 16'(cpu_clken), 16'd1);
      tick();
    end
    chk("2m_clken_count", 16'(cnt), 16'd2);

    // 4 MHz write of $55 to $1000 at slot 4, readback at slot 8
    turbo = 2'b10;
    tick();
    run_to(0);
    run_to(5);
    for (int p = 5; p <= 8; p++) begin
      cpu_addr = 16'h1000; cpu_dout = 8'h55; cpu_rnw = 1'b0;
      #1;
      chk("wr_ram_we", 16'(ram_we), (p == 7) ? 16'd1 : 16'd0);
      if (p == 7) begin
        chk("wr_ram_addr", ram_addr, 16'h1000);
        chk("wr_ram_din",  16'(ram_din), 16'h55);
      end
      tick();
    end
    for (int p = 9; p <= 12; p++) begin
      cpu_addr = 16'h1000; cpu_rnw = 1'b1; cpu_dout = 8'h00;
      #1;
      if (p == 12) chk("rd_cpu_din", 16'(cpu_din), 16'h55);
      tick();
    end

    // video window, request held for a frame
    run_to(0);
    vid_req = 1'b1; vid_addr = 14'h3ABC;
    cnt = 0; vcnt = 0; first_ack = -1;
    for (int p = 0; p < 25; p++) begin
      #1;
      if (vid_ack) begin
        cnt++;
        if (first_ack < 0) first_ack = p;
      end
      if (vid_valid) vcnt++;
      if (p == 16) chk("vid_ram_addr", ram_addr, 16'h1ABC);
      if (p == 24) begin
        chk("vid_valid_p24", 16'(vid_valid), 16'd1);
        chk("vid_ack_p24",   16'(vid_ack),   16'd0);
      end
      tick();
    end
    chk("vid_ack_count",   16'(cnt),       16'd8);
    chk("vid_first_ack",   16'(first_ack), 16'd16);
    chk("vid_valid_count", 16'(vcnt),      16'd8);
    vid_req = 1'b0;

    // low-half mapping
    run_to(16);
    vid_req = 1'b1; vid_addr = 14'h0123;
    #1;
    chk("map_ram_addr", ram_addr, 16'h8123);
    chk("map_ack",      16'(vid_ack), 16'd1);
    tick();
    vid_req = 1'b0;

    // decode
    cpu_rnw = 1'b1; via1_dout = 8'h3C; via2_dout = 8'hC3;
    cpu_addr = 16'h9114;
    #1;
    chk("dec_via1_cs", 16'(via1_cs), 16'd1);
    chk("dec_via1_din", 16'(cpu_din), 16'h3C);
    tick();
    cpu_addr = 16'h9120;
    #1;
    chk("dec_via2_cs", 16'(via2_cs), 16'd1);
    chk("dec_via2_din", 16'(cpu_din), 16'hC3);
    tick();
    mem[16'h9130] = 8'h77;
    cpu_addr = 16'h9130;
    tick();
    #1;
    chk("dec_none_cs", 16'({via1_cs, via2_cs}), 16'd0);
    chk("dec_ram_din", 16'(cpu_din), 16'h77);
    tick();

    // reset in the middle of a fetch
    run_to(16);
    vid_req = 1'b1; vid_addr = 14'h3000;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; vid_req = 1'b0;
    #1;
    chk("rstfetch_clken", 16'(cpu_clken), 16'd1);
    chk("rstfetch_valid", 16'(vid_valid), 16'd0);
    tick();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) turbo = 2'($urandom);
      cpu_addr = ($urandom_range(0, 1) == 0) ? {8'h91, 8'($urandom)} : 16'($urandom);
      cpu_rnw  = ($urandom_range(0, 2) != 0);
      cpu_dout = 8'($urandom);
      via1_dout = 8'($urandom);
      via2_dout = 8'($urandom);
      if (!(vid_req && !last_ack)) begin
        vid_req  = ($urandom_range(0, 3) == 0);
        vid_addr = 14'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
